register_file16: RTL and testbench



---
 rtl/simple_pkg.sv | 8 +
 rtl/register_file16_if.sv | 25 ++
 rtl/reg16.sv | 20 ++
 rtl/register_file16.sv | 56 +++++
 tb/tb_register_file16.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// Shared datapath constants for the simple CPU: word width, register count, address width.
package simple_pkg;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;

  localparam logic [WIDTH-1:0] WORD_ZERO = 16'h0000;
endpackage

// File: rtl/register_file16_if.sv
// Operand-read, write-back and debug signals of the register file.
interface register_file16_if;
  import simple_pkg::*;

  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic             latch_ab;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b, latch_ab, wr_en, wr_addr, wr_data, dbg_addr,
    input  ar, br, dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, latch_ab, wr_en, wr_addr, wr_data, dbg_addr,
    output ar, br, dbg_data
  );
endinterface

// File: rtl/reg16.sv
// Word-wide enabled register with synchronous active-high clear.
module reg16
  import simple_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= WORD_ZERO;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file16.sv
// Eight-entry register file with latched A/B operands and write-first bypass.
module register_file16
  import simple_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  register_file16_if.slave  bus
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  // Architectural registers; each entry loads only when it is the write target.
  for (genvar i = 0; i < int'(NREGS); i++) begin : g_regs
    reg16 u_reg (
      .clk (clk),
      .rst (rst),
      .en  (bus.wr_en && (bus.wr_addr == AW'(i))),
      .d   (bus.wr_data),
      .q   (regs[i])
    );
  end

  // Write-back data takes priority so a result can be consumed on the edge that writes it.
  always_comb begin
    a_next = regs[bus.rd_addr_a];
    b_next = regs[bus.rd_addr_b];
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      a_next = bus.wr_data;
    end
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      b_next = bus.wr_data;
    end
  end

  reg16 u_ar (
    .clk (clk),
    .rst (rst),
    .en  (bus.latch_ab),
    .d   (a_next),
    .q   (bus.ar)
  );

  reg16 u_br (
    .clk (clk),
    .rst (rst),
    .en  (bus.latch_ab),
    .d   (b_next),
    .q   (bus.br)
  );

  // Debug view is the array itself, never the bypass.
  assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_register_file16.sv
// Directed bench for register_file16: reset, write/read, bypass, hold, reset priority, boundary registers.
module tb_register_file16;
  import simple_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  register_file16_if bus ();

  register_file16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.latch_ab = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en     = 1'b1;
      bus.wr_addr   = AW'($urandom_range(0, 7));
      bus.wr_data   = WIDTH'($urandom);
      bus.latch_ab  = 1'b1;
      bus.rd_addr_a = AW'($urandom_range(0, 7));
      bus.rd_addr_b = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.ar !== 16'h0000) begin
      bad++;
      $display("FAIL reset_ar: got %h want 0000", bus.ar);
    end
    total++;
    if (bus.br !== 16'h0000) begin
      bad++;
      $display("FAIL reset_br: got %h want 0000", bus.br);
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = AW'(i);
      #1;
      total++;
      if (bus.dbg_data !== 16'h0000) begin
        bad++;
        $display("FAIL reset_dbg r%0d: got %h want 0000", i, bus.dbg_data);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(3'd3, 16'h1234);
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd3;
    bus.rd_addr_b = 3'd0;
    tick();
    bus.latch_ab  = 1'b0;
    total++;
    if (bus.ar !== 16'h1234) begin
      bad++;
      $display("FAIL write_read_ar: got %h want 1234", bus.ar);
    end
    total++;
    if (bus.br !== 16'h0000) begin
      bad++;
      $display("FAIL write_read_br: got %h want 0000", bus.br);
    end
  endtask

  task automatic test_bypass();
    bus.dbg_addr  = 3'd5;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd5;
    bus.wr_data   = 16'hBEEF;
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd5;
    bus.rd_addr_b = 3'd5;
    #1;
    total++;
    if (bus.dbg_data !== 16'h0000) begin
      bad++;
      $display("FAIL bypass_dbg_before: got %h want 0000", bus.dbg_data);
    end
    tick();
    idle();
    total++;
    if (bus.ar !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass_ar: got %h want beef", bus.ar);
    end
    total++;
    if (bus.br !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass_br: got %h want beef", bus.br);
    end
    total++;
    if (bus.dbg_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass_dbg_after: got %h want beef", bus.dbg_data);
    end
    // Bypass on A only; B reads r5 from the array.
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd2;
    bus.wr_data   = 16'h0F0F;
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd2;
    bus.rd_addr_b = 3'd5;
    tick();
    idle();
    total++;
    if (bus.ar !== 16'h0F0F) begin
      bad++;
      $display("FAIL bypass_split_ar: got %h want 0f0f", bus.ar);
    end
    total++;
    if (bus.br !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass_split_br: got %h want beef", bus.br);
    end
  endtask

  task automatic test_hold();
    do_write(3'd1, 16'h0011);
    do_write(3'd2, 16'h0022);
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd1;
    bus.rd_addr_b = 3'd2;
    tick();
    bus.latch_ab  = 1'b0;
    bus.rd_addr_a = 3'd5;
    bus.rd_addr_b = 3'd6;
    do_write(3'd1, 16'hAAAA);
    do_write(3'd2, 16'hBBBB);
    tick();
    total++;
    if (bus.ar !== 16'h0011) begin
      bad++;
      $display("FAIL hold_ar: got %h want 0011", bus.ar);
    end
    total++;
    if (bus.br !== 16'h0022) begin
      bad++;
      $display("FAIL hold_br: got %h want 0022", bus.br);
    end
    bus.dbg_addr = 3'd1;
    #1;
    total++;
    if (bus.dbg_data !== 16'hAAAA) begin
      bad++;
      $display("FAIL hold_dbg_r1: got %h want aaaa", bus.dbg_data);
    end
  endtask

  task automatic test_reset_dominates();
    rst           = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd4;
    bus.wr_data   = 16'h5555;
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd4;
    bus.rd_addr_b = 3'd1;
    tick();
    idle();
    bus.dbg_addr = 3'd4;
    #1;
    total++;
    if (bus.dbg_data !== 16'h0000) begin
      bad++;
      $display("FAIL rst_dom_r4: got %h want 0000", bus.dbg_data);
    end
    total++;
    if (bus.ar !== 16'h0000) begin
      bad++;
      $display("FAIL rst_dom_ar: got %h want 0000", bus.ar);
    end
    total++;
    if (bus.br !== 16'h0000) begin
      bad++;
      $display("FAIL rst_dom_br: got %h want 0000", bus.br);
    end
    // Reset between a write and the next capture.
    do_write(3'd6, 16'h7777);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd6;
    bus.rd_addr_b = 3'd6;
    tick();
    bus.latch_ab  = 1'b0;
    total++;
    if (bus.ar !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_ar: got %h want 0000", bus.ar);
    end
  endtask

  task automatic test_boundary();
    for (int i = 1; i < 7; i++) begin
      do_write(AW'(i), 16'h1100 + 16'(i));
    end
    do_write(3'd7, 16'hFFFF);
    do_write(3'd0, 16'h0001);
    bus.latch_ab  = 1'b1;
    bus.rd_addr_a = 3'd7;
    bus.rd_addr_b = 3'd0;
    tick();
    bus.latch_ab  = 1'b0;
    total++;
    if (bus.ar !== 16'hFFFF) begin
      bad++;
      $display("FAIL boundary_ar: got %h want ffff", bus.ar);
    end
    total++;
    if (bus.br !== 16'h0001) begin
      bad++;
      $display("FAIL boundary_br: got %h want 0001", bus.br);
    end
    for (int i = 1; i < 7; i++) begin
      bus.dbg_addr = AW'(i);
      #1;
      total++;
      if (bus.dbg_data !== 16'h1100 + 16'(i)) begin
        bad++;
        $display("FAIL boundary_keep r%0d: got %h want %h", i, bus.dbg_data, 16'h1100 + 16'(i));
      end
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.latch_ab  = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.dbg_addr  = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_hold();
    test_reset_dominates();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
